ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have one clock, clk_i; all state updates occur on its rising edge.
REQ-002 SHALL use reset rst_i, synchronous and active-low; no asynchronous paths.
REQ-003 Ports, in order (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  sync active-low reset
- start_i  in  1  EX-stage instruction from ID/EX register is a mult/div; valid this cycle
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- RDData0_i  in  32  rs operand (multiplicand/dividend)
- RDData1_i  in  32  rt operand (multiplier/divisor)
- flush_i  in  1  abort in-flight operation (branch/jump squash)
- stall_o  out  1  hold IF/ID and ID/EX registers
- done_o  out  1  result valid pulse
- hi_o  out  32  HI register
- lo_o  out  32  LO register

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-005 IDLE: start_i=1 and flush_i=0 -> latch op_i, operand magnitudes and sign bits (signed ops only), clear 6-bit iteration counter; next state RUN.
REQ-006 IDLE: start_i=1 with flush_i=1 -> flush wins; remain IDLE, nothing latched.
REQ-007 RUN: one radix-2 iteration per cycle (shift-add multiply / restoring divide on 32-bit magnitudes); counter increments; after the 32nd RUN cycle -> DONE.
REQ-008 RUN->DONE edge SHALL load hi_o/lo_o: multiply -> {hi,lo}=64-bit product; divide -> lo=quotient, hi=remainder.
REQ-009 Signed ops: product negated iff operand signs differ; quotient negated iff signs differ; remainder takes dividend sign.
REQ-010 DIV -2^31 / -1 SHALL yield lo=32'h80000000, hi=0 (no trap).
REQ-011 Divisor zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=RDData0_i as latched, no sign correction; latency unchanged.
REQ-012 DONE: done_o=1 for exactly that cycle; next state IDLE unconditionally; start_i ignored in DONE.
REQ-013 stall_o = (IDLE and start_i and not flush_i) or RUN; 0 in DONE; 0 while rst_i=0.
REQ-014 Latency: start accepted in cycle N -> RUN cycles N+1..N+32 -> DONE in cycle N+33, hi_o/lo_o new values visible from N+33; stall_o high cycles N..N+32 (33 cycles).
REQ-015 start_i in RUN SHALL be ignored (no restart, no latch).
REQ-016 flush_i in RUN -> IDLE next edge; hi_o/lo_o keep previous values; done_o not asserted; stall_o low from next cycle.
REQ-017 flush_i in DONE SHALL NOT undo the HI/LO update already made.
REQ-018 hi_o/lo_o SHALL change only on RUN->DONE edge or reset.

Reset
REQ-019 rst_i=0 at an edge -> state IDLE, hi_o=0, lo_o=0, done_o=0, counter=0, latched operands cleared; applies mid-operation, result discarded.
REQ-020 Reset SHALL take priority over start_i and flush_i.

Verification
REQ-021 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> DONE at N+33, hi=32'hFFFFFFFE, lo=32'h00000001, stall_o high exactly 33 cycles.
REQ-022 MULT -7 x 3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-023 DIVU 100 / 0 -> lo=32'hFFFFFFFF, hi=100; DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-024 Start DIVU 9/2, flush_i at RUN cycle 10 -> IDLE next cycle, stall_o low, done_o never pulses, hi/lo unchanged from prior result.
REQ-025 rst_i=0 at RUN cycle 20 of MULTU -> hi=lo=0, done_o=0, stall_o=0; new start after release completes normally in 33 cycles.
REQ-026 start_i held high through RUN and DONE -> exactly one operation; a second start accepted only in the IDLE cycle after DONE.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative EX-stage multiply/divide unit producing HI/LO.
// One radix-2 step per cycle (shift-add multiply, restoring divide) on
// operand magnitudes, with sign correction applied when the result is loaded.
//
// state | meaning
// IDLE  | waiting for a mult/div; accepts start unless squashed by flush
// RUN   | 32 iteration cycles; flush aborts without touching HI/LO
// DONE  | HI/LO just loaded; done_o pulses for this single cycle
module ex_muldiv (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] RDData0_i,
    input  logic [31:0] RDData1_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  op_q;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        sign_a;
    logic        sign_b;
    logic [5:0]  cnt;
    logic [31:0] work_hi;
    logic [31:0] work_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // operand capture: op_i[0]==0 selects the signed variants
    logic        signed_in;
    logic        neg_a_in;
    logic        neg_b_in;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;
    logic        start_ok;
    logic        last_iter;

    assign signed_in = ~op_i[0];
    assign neg_a_in  = signed_in & RDData0_i[31];
    assign neg_b_in  = signed_in & RDData1_i[31];
    assign mag_a_in  = neg_a_in ? (~RDData0_i + 32'd1) : RDData0_i;
    assign mag_b_in  = neg_b_in ? (~RDData1_i + 32'd1) : RDData1_i;
    assign start_ok  = (state == ST_IDLE) && start_i && !flush_i;
    assign last_iter = (cnt == 6'd31);

    // iteration datapath; work_hi/work_lo hold partial product or remainder/quotient
    logic        is_div;
    logic [32:0] mul_sum;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic [32:0] div_shift;
    logic        div_fits;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic [31:0] iter_hi;
    logic [31:0] iter_lo;

    assign is_div    = op_q[1];
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_hi    = mul_sum[32:1];
    assign mul_lo    = {mul_sum[0], work_lo[31:1]};
    assign div_shift = {work_hi, work_lo[31]};
    assign div_fits  = (div_shift >= {1'b0, mag_b});
    // the restored remainder is always below the divisor, so 32 bits suffice
    assign div_hi    = div_fits ? (div_shift[31:0] - mag_b) : div_shift[31:0];
    assign div_lo    = {work_lo[30:0], div_fits};
    assign iter_hi   = is_div ? div_hi : mul_hi;
    assign iter_lo   = is_div ? div_lo : mul_lo;

    // final result with sign correction; divide-by-zero bypasses it
    logic        neg_res;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] dividend_raw;
    logic        div_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign neg_res      = sign_a ^ sign_b;
    assign prod         = {iter_hi, iter_lo};
    assign prod_fix     = neg_res ? (~prod + 64'd1) : prod;
    assign quot_fix     = neg_res ? (~iter_lo + 32'd1) : iter_lo;
    assign rem_fix      = sign_a ? (~iter_hi + 32'd1) : iter_hi;
    assign dividend_raw = sign_a ? (~mag_a + 32'd1) : mag_a;
    assign div_zero     = (mag_b == 32'd0);

    // pick the value that lands in HI/LO on the RUN->DONE edge
    always_comb begin
        res_hi = prod_fix[63:32];
        res_lo = prod_fix[31:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = dividend_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quot_fix;
            end
        end
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; flush in RUN abandons the operation
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_next = ST_IDLE;
                end else if (last_iter) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // operand latch and iteration registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            op_q    <= 2'b00;
            mag_a   <= 32'd0;
            mag_b   <= 32'd0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            cnt     <= 6'd0;
            work_hi <= 32'd0;
            work_lo <= 32'd0;
        end else if (start_ok) begin
            op_q    <= op_i;
            mag_a   <= mag_a_in;
            mag_b   <= mag_b_in;
            sign_a  <= neg_a_in;
            sign_b  <= neg_b_in;
            cnt     <= 6'd0;
            work_hi <= 32'd0;
            work_lo <= op_i[1] ? mag_a_in : mag_b_in;
        end else if (state == ST_RUN && !flush_i) begin
            cnt     <= cnt + 6'd1;
            work_hi <= iter_hi;
            work_lo <= iter_lo;
        end
    end

    // HI/LO update only when the last iteration completes
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (state == ST_RUN && !flush_i && last_iter) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end
    end

    assign stall_o = rst_i && (start_ok || (state == ST_RUN));
    assign done_o  = (state == ST_DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed tests for the iterative multiply/divide unit.
module tb_ex_muldiv;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] RDData0_i = 32'd0;
    logic [31:0] RDData1_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int tests_run = 0;
    int tests_failed = 0;

    ex_muldiv dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .RDData0_i (RDData0_i),
        .RDData1_i (RDData1_i),
        .flush_i   (flush_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus only: issue one op, report latency to done, stall count, HI/LO.
    // Returns at the negedge of the DONE cycle (or after 100 cycles).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls,
                         output logic [31:0] h, output logic [31:0] l);
        bit seen;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; RDData0_i = a; RDData1_i = b; flush_i = 1'b0;
        #1;
        lat = 0; stalls = 0; seen = 1'b0;
        if (stall_o) stalls++;
        while (!seen && lat < 100) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            lat++;
            if (stall_o) stalls++;
            if (done_o) seen = 1'b1;
        end
        h = hi_o; l = lo_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b1; op_i = OP_MULTU;
        RDData0_i = 32'd5; RDData1_i = 32'd5;
        repeat (2) @(negedge clk_i);
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", stall_o); end
        tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done_o); end
        tests_run++; if (hi_o !== 32'd0) begin tests_failed++; $display("FAIL reset_hi got %h want 0", hi_o); end
        tests_run++; if (lo_o !== 32'd0) begin tests_failed++; $display("FAIL reset_lo got %h want 0", lo_o); end
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_multu();
        int lat, st;
        logic [31:0] h, l;
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, st, h, l);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL multu_latency got %0d want 33", lat); end
        tests_run++; if (st !== 33) begin tests_failed++; $display("FAIL multu_stall_cycles got %0d want 33", st); end
        tests_run++; if (h !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_hi got %h want fffffffe", h); end
        tests_run++; if (l !== 32'h0000_0001) begin tests_failed++; $display("FAIL multu_lo got %h want 00000001", l); end
        // flush arriving in DONE must not undo the update
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        tests_run++; if (hi_o !== 32'hFFFF_FFFE || lo_o !== 32'h0000_0001) begin
            tests_failed++; $display("FAIL flush_in_done got %h_%h want fffffffe_00000001", hi_o, lo_o); end
        do_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, lat, st, h, l);
        tests_run++; if (h !== 32'd1 || l !== 32'd0) begin tests_failed++; $display("FAIL multu_2p32 got %h_%h want 00000001_00000000", h, l); end
    endtask

    task automatic test_mult_signed();
        int lat, st;
        logic [31:0] h, l;
        do_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, lat, st, h, l);
        tests_run++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mult_m7x3 got %h_%h want ffffffff_ffffffeb", h, l); end
        do_op(OP_MULT, 32'd5, 32'hFFFF_FFFA, lat, st, h, l);
        tests_run++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFE2) begin tests_failed++; $display("FAIL mult_5xm6 got %h_%h want ffffffff_ffffffe2", h, l); end
        do_op(OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, lat, st, h, l);
        tests_run++; if (h !== 32'd0 || l !== 32'd20) begin tests_failed++; $display("FAIL mult_m4xm5 got %h_%h want 00000000_00000014", h, l); end
    endtask

    task automatic test_div();
        int lat, st;
        logic [31:0] h, l;
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, st, h, l);
        tests_run++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_m7d2 got %h_%h want ffffffff_fffffffd", h, l); end
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL div_latency got %0d want 33", lat); end
        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, st, h, l);
        tests_run++; if (h !== 32'd1 || l !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_7dm2 got %h_%h want 00000001_fffffffd", h, l); end
        do_op(OP_DIVU, 32'd100, 32'd7, lat, st, h, l);
        tests_run++; if (h !== 32'd2 || l !== 32'd14) begin tests_failed++; $display("FAIL divu_100d7 got %h_%h want 00000002_0000000e", h, l); end
        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat, st, h, l);
        tests_run++; if (h !== 32'd0 || l !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divu_max_d1 got %h_%h want 00000000_ffffffff", h, l); end
    endtask

    task automatic test_div_zero();
        int lat, st;
        logic [31:0] h, l;
        do_op(OP_DIVU, 32'd100, 32'd0, lat, st, h, l);
        tests_run++; if (h !== 32'd100 || l !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divu_by_zero got %h_%h want 00000064_ffffffff", h, l); end
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL div_zero_latency got %0d want 33", lat); end
        do_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, st, h, l);
        tests_run++; if (h !== 32'hFFFF_FFFB || l !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_m5_by_zero got %h_%h want fffffffb_ffffffff", h, l); end
    endtask

    task automatic test_div_overflow();
        int lat, st;
        logic [31:0] h, l;
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, h, l);
        tests_run++; if (h !== 32'd0 || l !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_overflow got %h_%h want 00000000_80000000", h, l); end
    endtask

    // HI=0, LO=80000000 is left over from the overflow test
    task automatic test_flush();
        int cyc, dones;
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; RDData0_i = 32'd9; RDData1_i = 32'd2;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_stall got %b want 0", stall_o); end
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        tests_run++; if (stall_o !== 1'b0 || done_o !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_not_started got stall=%b done=%b want 0 0", stall_o, done_o); end
        // start DIVU 9/2 and squash it in RUN cycle 10
        start_i = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            cyc++;
        end
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL flush_run_stall_before got %b want 1", stall_o); end
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL flush_run_stall_after got %b want 0", stall_o); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) dones++;
            @(negedge clk_i);
            #1;
        end
        tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL flush_run_done_pulses got %0d want 0", dones); end
        tests_run++; if (hi_o !== 32'd0 || lo_o !== 32'h8000_0000) begin tests_failed++; $display("FAIL flush_run_hilo got %h_%h want 00000000_80000000", hi_o, lo_o); end
    endtask

    task automatic test_reset_mid();
        int cyc, lat, st;
        logic [31:0] h, l;
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_MULTU; RDData0_i = 32'h1234_5678; RDData1_i = 32'd9;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            cyc++;
        end
        rst_i = 1'b0;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_stall_comb got %b want 0", stall_o); end
        @(negedge clk_i);
        #1;
        tests_run++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin tests_failed++; $display("FAIL midreset_hilo got %h_%h want 0_0", hi_o, lo_o); end
        tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_done got %b want 0", done_o); end
        rst_i = 1'b1;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_stall_after got %b want 0", stall_o); end
        do_op(OP_MULTU, 32'd3, 32'd4, lat, st, h, l);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL midreset_restart_latency got %0d want 33", lat); end
        tests_run++; if (h !== 32'd0 || l !== 32'd12) begin tests_failed++; $display("FAIL midreset_restart_result got %h_%h want 00000000_0000000c", h, l); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk_i);
        start_i = 1'b1; op_i = OP_MULTU; RDData0_i = 32'd6; RDData1_i = 32'd7;
        #1;
        cyc = 0;
        while (!done_o && cyc < 100) begin
            @(negedge clk_i);
            if (cyc == 5) begin RDData0_i = 32'd100; RDData1_i = 32'd100; op_i = OP_DIVU; end
            #1;
            cyc++;
        end
        tests_run++; if (cyc !== 33) begin tests_failed++; $display("FAIL b2b_first_latency got %0d want 33", cyc); end
        tests_run++; if (lo_o !== 32'd42 || hi_o !== 32'd0) begin tests_failed++; $display("FAIL b2b_first_result got %h_%h want 00000000_0000002a", hi_o, lo_o); end
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_stall got %b want 0", stall_o); end
        @(negedge clk_i);
        op_i = OP_MULTU; RDData0_i = 32'd2; RDData1_i = 32'd3;
        #1;
        tests_run++; if (stall_o !== 1'b1 || done_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_accept got stall=%b done=%b want 1 0", stall_o, done_o); end
        cyc = 0;
        while (!done_o && cyc < 100) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            cyc++;
        end
        tests_run++; if (cyc !== 33) begin tests_failed++; $display("FAIL b2b_second_latency got %0d want 33", cyc); end
        tests_run++; if (lo_o !== 32'd6 || hi_o !== 32'd0) begin tests_failed++; $display("FAIL b2b_second_result got %h_%h want 00000000_00000006", hi_o, lo_o); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_signed();
        test_div();
        test_div_zero();
        test_div_overflow();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
